// File: rtl/alu_result_packer_pkg.sv
// rtl/alu_result_packer_pkg.sv - shared types and widths for the ALU result packer
package alu_pkg;

  localparam int RESULT_W = 16;
  localparam int BYTE_W   = 8;

  // SEND_CK is only ever entered when the checksum byte is built in
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2,
    SEND_CK = 2'd3
  } packer_state_e;

endpackage

// File: rtl/alu_result_packer_if.sv
// rtl/alu_result_packer_if.sv - result capture, byte transmit and status bundle
interface alu_result_packer_if #(
  parameter int DEPTH = 4
) ();
  import alu_pkg::*;

  logic [RESULT_W-1:0]      ALU_OUT;
  logic                     OUT_VALID;
  logic                     TX_READY;
  logic [BYTE_W-1:0]        TX_DATA;
  logic                     TX_VALID;
  logic                     OVF_CLR;
  logic                     OVERFLOW;
  logic [$clog2(DEPTH):0]   FIFO_COUNT;
  logic                     BUSY;

  // ALU / sink / status-reader side
  modport master (
    output ALU_OUT, OUT_VALID, TX_READY, OVF_CLR,
    input  TX_DATA, TX_VALID, OVERFLOW, FIFO_COUNT, BUSY
  );

  // packer side
  modport slave (
    input  ALU_OUT, OUT_VALID, TX_READY, OVF_CLR,
    output TX_DATA, TX_VALID, OVERFLOW, FIFO_COUNT, BUSY
  );
endinterface

// File: rtl/alu_result_packer_fifo.sv
// rtl/alu_result_packer_fifo.sv - synchronous DEPTH x W result FIFO with occupancy count
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // a push into a full FIFO is still legal when a pop frees the slot this cycle
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  // pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/alu_result_packer.sv
// rtl/alu_result_packer.sv - buffers ALU results and sends them low byte first; RESULT_CHECKSUM_EN adds an XOR byte
module alu_result_packer
  import alu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16
) (
  input  logic               CLK,
  input  logic               RST,
  alu_result_packer_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  if (DATA_W != 2 * BYTE_W) begin : g_bad_data_w
    $error("alu_result_packer: DATA_W must be exactly two bytes");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("alu_result_packer: DEPTH must be a power of two, at least 2");
  end

  packer_state_e       state_q, state_d;
  logic [RESULT_W-1:0] hold_q, hold_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                overflow_q, overflow_d;

  logic [RESULT_W-1:0] fifo_rdata;
  logic                fifo_full, fifo_empty, fifo_pop, drop;
  logic [CW-1:0]       fifo_count;

  // the only pop: an idle FSM loading the hold register
  assign fifo_pop = (state_q == IDLE) && !fifo_empty;
  assign drop     = bus.OUT_VALID && fifo_full && !fifo_pop;

  result_fifo #(.DEPTH(DEPTH), .W(RESULT_W)) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (bus.OUT_VALID),
    .pop   (fifo_pop),
    .wdata (bus.ALU_OUT),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // frame sequencer: each byte advances on one TX_VALID && TX_READY edge
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          hold_d     = fifo_rdata;
          tx_data_d  = fifo_rdata[BYTE_W-1:0];
          tx_valid_d = 1'b1;
          state_d    = SEND_LO;
        end
      end
      SEND_LO: begin
        if (bus.TX_READY) begin
          tx_data_d = hold_q[RESULT_W-1:BYTE_W];
          state_d   = SEND_HI;
        end
      end
      SEND_HI: begin
        if (bus.TX_READY) begin
`ifdef RESULT_CHECKSUM_EN
          tx_data_d = hold_q[BYTE_W-1:0] ^ hold_q[RESULT_W-1:BYTE_W];
          state_d   = SEND_CK;
`else
          tx_valid_d = 1'b0;
          state_d    = IDLE;
`endif
        end
      end
`ifdef RESULT_CHECKSUM_EN
      SEND_CK: begin
        if (bus.TX_READY) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
`endif
      default: begin
        tx_valid_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // sticky overflow; a drop in the same cycle as a clear wins
  always_comb begin
    overflow_d = overflow_q;
    if (bus.OVF_CLR) overflow_d = 1'b0;
    if (drop)        overflow_d = 1'b1;
  end

  // sequencer, hold and status registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.TX_DATA    = tx_data_q;
  assign bus.TX_VALID   = tx_valid_q;
  assign bus.OVERFLOW   = overflow_q;
  assign bus.FIFO_COUNT = fifo_count;
  assign bus.BUSY       = (fifo_count != '0) || (state_q != IDLE);
endmodule

// File: tb/tb_alu_result_packer.sv
// tb/tb_alu_result_packer.sv - self-checking bench for alu_result_packer
module tb_alu_result_packer;
  localparam int DEPTH = 4;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  alu_result_packer_if #(.DEPTH(DEPTH)) bus ();

  alu_result_packer #(.DEPTH(DEPTH), .DATA_W(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] din;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [7:0]  ck;
  } vec_t;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q [$];

  function automatic void check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_frame(input logic [15:0] d);
    exp_q.push_back(d[7:0]);
    exp_q.push_back(d[15:8]);
`ifdef RESULT_CHECKSUM_EN
    exp_q.push_back(d[7:0] ^ d[15:8]);
`endif
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (bus.BUSY && n < max_cycles) begin
      tick();
      n++;
    end
    check("drain_within_budget", {15'd0, bus.BUSY}, 16'd0);
  endtask

  // every accepted byte must match the head of the expected stream
  always @(negedge CLK) begin
    if (RST === 1'b0 && bus.TX_VALID === 1'b1 && bus.TX_READY === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected_byte: got %02h, expected no byte (t=%0t)", bus.TX_DATA, $time);
      end else begin
        check("sb_byte", {8'h00, bus.TX_DATA}, {8'h00, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    vec_t vecs [6];
    int   i, guard;
    vecs[0] = '{16'hA55A, 8'h5A, 8'hA5, 8'hFF};
    vecs[1] = '{16'h1234, 8'h34, 8'h12, 8'h26};
    vecs[2] = '{16'hFFFF, 8'hFF, 8'hFF, 8'h00};
    vecs[3] = '{16'h0000, 8'h00, 8'h00, 8'h00};
    vecs[4] = '{16'hBEEF, 8'hEF, 8'hBE, 8'h51};
    vecs[5] = '{16'h8001, 8'h01, 8'h80, 8'h81};

    RST = 1'b1;
    bus.ALU_OUT = 16'h0;
    bus.OUT_VALID = 1'b0;
    bus.TX_READY = 1'b1;
    bus.OVF_CLR = 1'b0;
    tick();
    tick();
    check("rst_tx_valid", {15'd0, bus.TX_VALID}, 16'd0);
    check("rst_tx_data", {8'd0, bus.TX_DATA}, 16'd0);
    check("rst_count", {13'd0, bus.FIFO_COUNT}, 16'd0);
    check("rst_overflow", {15'd0, bus.OVERFLOW}, 16'd0);
    check("rst_busy", {15'd0, bus.BUSY}, 16'd0);
    RST = 1'b0;
    tick();

    // single results with the sink always ready: fixed latency per byte
    foreach (vecs[k]) begin
      bus.ALU_OUT = vecs[k].din;
      bus.OUT_VALID = 1'b1;
      expect_frame(vecs[k].din);
      tick();
      bus.OUT_VALID = 1'b0;
      check("vec_count_after_push", {13'd0, bus.FIFO_COUNT}, 16'd1);
      check("vec_busy_after_push", {15'd0, bus.BUSY}, 16'd1);
      tick();
      check("vec_lo_valid", {15'd0, bus.TX_VALID}, 16'd1);
      check("vec_lo_data", {8'd0, bus.TX_DATA}, {8'd0, vecs[k].lo});
      check("vec_count_after_pop", {13'd0, bus.FIFO_COUNT}, 16'd0);
      tick();
      check("vec_hi_data", {8'd0, bus.TX_DATA}, {8'd0, vecs[k].hi});
`ifdef RESULT_CHECKSUM_EN
      tick();
      check("vec_ck_data", {8'd0, bus.TX_DATA}, {8'd0, vecs[k].ck});
`endif
      tick();
      check("vec_done_valid", {15'd0, bus.TX_VALID}, 16'd0);
      check("vec_done_busy", {15'd0, bus.BUSY}, 16'd0);
    end

    // back-to-back results: one idle cycle between frames
    bus.ALU_OUT = 16'h1111;
    bus.OUT_VALID = 1'b1;
    expect_frame(16'h1111);
    tick();
    bus.ALU_OUT = 16'h2222;
    expect_frame(16'h2222);
    tick();
    bus.OUT_VALID = 1'b0;
    tick();
`ifdef RESULT_CHECKSUM_EN
    tick();
`endif
    tick();
    check("b2b_gap_valid", {15'd0, bus.TX_VALID}, 16'd0);
    check("b2b_gap_count", {13'd0, bus.FIFO_COUNT}, 16'd1);
    tick();
    check("b2b_second_lo", {8'd0, bus.TX_DATA}, 16'h0022);
    wait_idle(50);

    // backpressure on the low byte
    bus.TX_READY = 1'b0;
    bus.ALU_OUT = 16'h1234;
    bus.OUT_VALID = 1'b1;
    expect_frame(16'h1234);
    tick();
    bus.OUT_VALID = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      check("bp_hold_data", {8'd0, bus.TX_DATA}, 16'h0034);
      check("bp_hold_valid", {15'd0, bus.TX_VALID}, 16'd1);
      tick();
    end
    bus.TX_READY = 1'b1;
    tick();
    check("bp_hi_data", {8'd0, bus.TX_DATA}, 16'h0012);
    wait_idle(50);

    // overflow: 0001 held, 0002..0005 queued, 0006 dropped
    bus.TX_READY = 1'b0;
    for (int v = 1; v <= 6; v++) begin
      bus.ALU_OUT = 16'(v);
      bus.OUT_VALID = 1'b1;
      if (v <= 5) expect_frame(16'(v));
      tick();
    end
    bus.OUT_VALID = 1'b0;
    check("ovf_count_full", {13'd0, bus.FIFO_COUNT}, 16'd4);
    check("ovf_set", {15'd0, bus.OVERFLOW}, 16'd1);
    check("ovf_hold_lo", {8'd0, bus.TX_DATA}, 16'h0001);
    bus.OVF_CLR = 1'b1;
    tick();
    bus.OVF_CLR = 1'b0;
    check("ovf_cleared", {15'd0, bus.OVERFLOW}, 16'd0);
    bus.OVF_CLR = 1'b1;
    bus.ALU_OUT = 16'h0007;
    bus.OUT_VALID = 1'b1;
    tick();
    bus.OVF_CLR = 1'b0;
    bus.OUT_VALID = 1'b0;
    check("ovf_set_wins", {15'd0, bus.OVERFLOW}, 16'd1);
    bus.OVF_CLR = 1'b1;
    tick();
    bus.OVF_CLR = 1'b0;
    check("ovf_cleared_again", {15'd0, bus.OVERFLOW}, 16'd0);

    // full FIFO: push lands in the same cycle as the idle pop
    bus.TX_READY = 1'b1;
    tick();
    tick();
`ifdef RESULT_CHECKSUM_EN
    tick();
`endif
    bus.TX_READY = 1'b0;
    check("col_idle_valid", {15'd0, bus.TX_VALID}, 16'd0);
    check("col_idle_count", {13'd0, bus.FIFO_COUNT}, 16'd4);
    bus.ALU_OUT = 16'hBEEF;
    bus.OUT_VALID = 1'b1;
    expect_frame(16'hBEEF);
    tick();
    bus.OUT_VALID = 1'b0;
    check("col_count_kept", {13'd0, bus.FIFO_COUNT}, 16'd4);
    check("col_no_overflow", {15'd0, bus.OVERFLOW}, 16'd0);
    check("col_next_lo", {8'd0, bus.TX_DATA}, 16'h0002);
    bus.TX_READY = 1'b1;
    wait_idle(200);

    // wrap-around with a toggling sink
    i = 0;
    guard = 0;
    bus.TX_READY = 1'b0;
    while ((i < 10 || bus.BUSY) && guard < 1000) begin
      if (i < 10 && bus.FIFO_COUNT < 3'(DEPTH)) begin
        bus.ALU_OUT = 16'h0100 + 16'(i);
        bus.OUT_VALID = 1'b1;
        expect_frame(16'h0100 + 16'(i));
        i++;
      end else begin
        bus.OUT_VALID = 1'b0;
      end
      bus.TX_READY = ~bus.TX_READY;
      tick();
      guard++;
    end
    bus.OUT_VALID = 1'b0;
    check("wrap_within_budget", 16'(guard < 1000), 16'd1);
    check("wrap_no_overflow", {15'd0, bus.OVERFLOW}, 16'd0);
    check("wrap_all_bytes", 16'(exp_q.size()), 16'd0);

    // reset in SEND_HI with three entries queued
    bus.TX_READY = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      bus.ALU_OUT = 16'hC000 + 16'(v);
      bus.OUT_VALID = 1'b1;
      tick();
    end
    bus.OUT_VALID = 1'b0;
    check("mid_count_3", {13'd0, bus.FIFO_COUNT}, 16'd3);
    exp_q.push_back(8'h01);
    bus.TX_READY = 1'b1;
    tick();
    bus.TX_READY = 1'b0;
    check("mid_in_hi", {8'd0, bus.TX_DATA}, 16'h00C0);
    RST = 1'b1;
    #1;
    check("mid_rst_valid", {15'd0, bus.TX_VALID}, 16'd0);
    check("mid_rst_count", {13'd0, bus.FIFO_COUNT}, 16'd0);
    check("mid_rst_busy", {15'd0, bus.BUSY}, 16'd0);
    check("mid_sb_empty", 16'(exp_q.size()), 16'd0);
    tick();
    RST = 1'b0;
    bus.TX_READY = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      check("post_rst_quiet", {15'd0, bus.TX_VALID}, 16'd0);
    end
    bus.ALU_OUT = 16'h5AA5;
    bus.OUT_VALID = 1'b1;
    expect_frame(16'h5AA5);
    tick();
    bus.OUT_VALID = 1'b0;
    wait_idle(50);

    check("final_sb_empty", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
